// File: rtl/spi_param_bank.sv
`default_nettype none
// ============================================================================
// Module   : spi_param_bank
// Brief    : SPI-loaded bank of parameter words with shadow buffering and an
//            atomic live update at the end of each writing frame.
// Revision : 1.0
// ============================================================================
module spi_param_bank #(
    parameter int                DATA_W    = 8,
    parameter int                NUM_CH    = 4,
    parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       spi_done,
    input  logic [7:0]                 spi_dout,
    input  logic                       spi_cs_n,
    output logic [NUM_CH*DATA_W-1:0]   params,
    output logic                       cfg_valid,
    output logic                       busy,
    output logic                       err
);

    localparam int                 C_BYTES     = DATA_W / 8;
    localparam int                 C_PTR_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [1:0]         C_LAST_BYTE = 2'(C_BYTES - 1);
    localparam logic [C_PTR_W-1:0] C_LAST_PTR  = C_PTR_W'(NUM_CH - 1);

    localparam logic [1:0] C_IDLE   = 2'd0;
    localparam logic [1:0] C_HEADER = 2'd1;
    localparam logic [1:0] C_DATA   = 2'd2;
    localparam logic [1:0] C_IGNORE = 2'd3;

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic               r_cs_q;
    logic               r_armed;
    logic               r_mode;
    logic               r_written;
    logic               r_cfg_valid;
    logic               r_err;
    logic [C_PTR_W-1:0] r_ptr;
    logic [1:0]         r_cnt;
    logic [DATA_W-1:0]  r_acc;
    logic [DATA_W-1:0]  r_shadow [NUM_CH];
    logic [DATA_W-1:0]  r_live   [NUM_CH];

    logic               w_frame_start;
    logic               w_frame_end;
    logic               w_accept;
    logic               w_addr_ok;
    logic               w_word_done;
    logic [DATA_W-1:0]  w_word;

    // r_armed blocks a false frame start when reset releases with cs_n already low
    assign w_frame_start = ~spi_cs_n & r_cs_q & r_armed;
    assign w_frame_end   = spi_cs_n & ~r_cs_q;
    assign w_accept      = spi_done & ~spi_cs_n;
    assign w_addr_ok     = ({1'b0, spi_dout[6:0]} < 8'(NUM_CH));
    assign w_word        = (r_acc << 8) | DATA_W'(spi_dout);
    assign w_word_done   = (r_state == C_DATA) & w_accept & (r_cnt == C_LAST_BYTE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= C_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_frame_end) begin
            w_state_nxt = C_IDLE;
        end else begin
            case (r_state)
                C_IDLE:   if (w_frame_start) w_state_nxt = C_HEADER;
                C_HEADER: if (w_accept) w_state_nxt = w_addr_ok ? C_DATA : C_IGNORE;
                C_DATA:   if (w_word_done && !r_mode) w_state_nxt = C_IGNORE;
                default:  w_state_nxt = r_state;
            endcase
        end
    end

    always_comb begin
        busy      = (r_state != C_IDLE);
        cfg_valid = r_cfg_valid;
        err       = r_err;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cs_q      <= 1'b1;
            r_armed     <= 1'b0;
            r_mode      <= 1'b0;
            r_written   <= 1'b0;
            r_cfg_valid <= 1'b0;
            r_err       <= 1'b0;
            r_ptr       <= '0;
            r_cnt       <= '0;
            r_acc       <= '0;
            for (int k = 0; k < NUM_CH; k++) begin
                r_shadow[k] <= RESET_VAL;
                r_live[k]   <= RESET_VAL;
            end
        end else begin
            r_cs_q      <= spi_cs_n;
            r_armed     <= r_armed | spi_cs_n;
            r_cfg_valid <= w_frame_end & r_written;

            if (w_frame_start) begin
                r_err <= 1'b0;
            end

            // Shadow already holds every word, written or not, so a full copy is atomic
            if (w_frame_end) begin
                if (r_written) begin
                    for (int k = 0; k < NUM_CH; k++) begin
                        r_live[k] <= r_shadow[k];
                    end
                end
                r_written <= 1'b0;
                r_cnt     <= '0;
            end

            if ((r_state == C_HEADER) && w_accept) begin
                if (w_addr_ok) begin
                    r_ptr  <= spi_dout[C_PTR_W-1:0];
                    r_mode <= spi_dout[7];
                    r_cnt  <= '0;
                    r_acc  <= '0;
                end else begin
                    r_err  <= 1'b1;
                end
            end

            if ((r_state == C_DATA) && w_accept) begin
                if (r_cnt == C_LAST_BYTE) begin
                    r_shadow[r_ptr] <= w_word;
                    r_written       <= 1'b1;
                    r_cnt           <= '0;
                    r_acc           <= '0;
                    r_ptr           <= (r_ptr == C_LAST_PTR) ? '0 : r_ptr + 1'b1;
                end else begin
                    r_acc <= w_word;
                    r_cnt <= r_cnt + 2'd1;
                end
            end
        end
    end

    generate
        for (genvar k = 0; k < NUM_CH; k++) begin : g_params
            assign params[k*DATA_W +: DATA_W] = r_live[k];
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_spi_param_bank.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_param_bank
// Brief    : Scoreboard bench for spi_param_bank (8-bit and 16-bit instances).
// Revision : 1.0
// ============================================================================
module tb_spi_param_bank;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        cs_a, done_a, cfg_a, busy_a, err_a;
    logic [7:0]  dout_a;
    logic [31:0] params_a;
    logic        cs_b, done_b, cfg_b, busy_b, err_b;
    logic [7:0]  dout_b;
    logic [63:0] params_b;

    spi_param_bank #(.DATA_W(8), .NUM_CH(4), .RESET_VAL(8'h00)) dut_a (
        .clk(clk), .rst(rst), .spi_done(done_a), .spi_dout(dout_a), .spi_cs_n(cs_a),
        .params(params_a), .cfg_valid(cfg_a), .busy(busy_a), .err(err_a)
    );

    spi_param_bank #(.DATA_W(16), .NUM_CH(4), .RESET_VAL(16'hA5A5)) dut_b (
        .clk(clk), .rst(rst), .spi_done(done_b), .spi_dout(dout_b), .spi_cs_n(cs_b),
        .params(params_b), .cfg_valid(cfg_b), .busy(busy_b), .err(err_b)
    );

    typedef struct packed {
        logic        err;
        logic [63:0] p;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    exp_t ea, eb;
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitors: every cfg_valid cycle consumes exactly one expected commit
    always @(negedge clk) begin
        if (rst === 1'b1 && cfg_a === 1'b1) begin
            if (qa.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL cfg_a_unexpected: got cfg_valid=1 expected 0");
            end else begin
                ea = qa.pop_front();
                check("params_a", 64'(params_a), ea.p);
                check("err_a_at_commit", 64'(err_a), 64'(ea.err));
            end
        end
    end

    always @(negedge clk) begin
        if (rst === 1'b1 && cfg_b === 1'b1) begin
            if (qb.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL cfg_b_unexpected: got cfg_valid=1 expected 0");
            end else begin
                eb = qb.pop_front();
                check("params_b", params_b, eb.p);
                check("err_b_at_commit", 64'(err_b), 64'(eb.err));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int which, input logic cs, input logic done, input logic [7:0] d);
        if (which == 0) begin
            cs_a = cs; done_a = done; dout_a = d;
        end else begin
            cs_b = cs; done_b = done; dout_b = d;
        end
    endtask

    task automatic open_frame(input int which);
        drive(which, 1'b0, 1'b0, 8'h00);
        tick(); tick();
    endtask

    task automatic send(input int which, input logic [7:0] b);
        drive(which, 1'b0, 1'b1, b);
        tick();
        drive(which, 1'b0, 1'b0, 8'h00);
        tick(); tick();
    endtask

    task automatic close_frame(input int which);
        drive(which, 1'b1, 1'b0, 8'h00);
        repeat (4) tick();
    endtask

    task automatic push_a(input logic [31:0] p);
        qa.push_back('{err: 1'b0, p: 64'(p)});
    endtask

    task automatic push_b(input logic [63:0] p);
        qb.push_back('{err: 1'b0, p: p});
    endtask

    initial begin
        rst = 1'b0;
        drive(0, 1'b1, 1'b0, 8'h00);
        drive(1, 1'b1, 1'b0, 8'h00);
        repeat (3) tick();

        check("reset_params_a", 64'(params_a), 64'h0);
        check("reset_busy_a",   64'(busy_a),   64'h0);
        check("reset_err_a",    64'(err_a),    64'h0);
        check("reset_cfg_a",    64'(cfg_a),    64'h0);
        check("reset_params_b", params_b,      64'hA5A5_A5A5_A5A5_A5A5);
        check("reset_busy_b",   64'(busy_b),   64'h0);

        rst = 1'b1;
        tick(); tick();

        // Burst of four words from address 0
        open_frame(0);
        send(0, 8'h80);
        check("busy_a_in_frame", 64'(busy_a), 64'h1);
        send(0, 8'h7F); send(0, 8'h0C); send(0, 8'h01); send(0, 8'h10);
        push_a(32'h1001_0C7F);
        close_frame(0);
        check("busy_a_after_frame", 64'(busy_a), 64'h0);

        // Single mode: second byte discarded
        open_frame(0);
        send(0, 8'h02); send(0, 8'h55); send(0, 8'h66);
        push_a(32'h1055_0C7F);
        close_frame(0);

        // Burst wrapping from word 3 to word 0
        open_frame(0);
        send(0, 8'h83); send(0, 8'hAA); send(0, 8'hBB);
        push_a(32'hAA55_0CBB);
        close_frame(0);

        // Out-of-range address: error, no update
        open_frame(0);
        send(0, 8'h05); send(0, 8'h11);
        close_frame(0);
        check("err_a_set",       64'(err_a),    64'h1);
        check("params_a_on_err", 64'(params_a), 64'hAA55_0CBB);
        open_frame(0);
        check("err_a_cleared",   64'(err_a),    64'h0);
        send(0, 8'h01); send(0, 8'h77);
        push_a(32'hAA55_77BB);
        close_frame(0);

        // Empty frame: start and end on consecutive cycles
        drive(0, 1'b0, 1'b0, 8'h00); tick();
        drive(0, 1'b1, 1'b0, 8'h00); repeat (4) tick();
        check("params_a_empty", 64'(params_a), 64'hAA55_77BB);

        // Bytes strobed with cs_n high are dropped
        drive(0, 1'b1, 1'b1, 8'h81); tick();
        drive(0, 1'b1, 1'b1, 8'h22); tick();
        drive(0, 1'b1, 1'b0, 8'h00); repeat (3) tick();
        check("busy_a_cs_high", 64'(busy_a), 64'h0);

        // Byte strobed in the frame-end cycle is dropped
        open_frame(0);
        send(0, 8'h82); send(0, 8'h33);
        push_a(32'hAA33_77BB);
        drive(0, 1'b1, 1'b1, 8'h44); tick();
        drive(0, 1'b1, 1'b0, 8'h00); repeat (4) tick();

        // Header-only frame writes nothing
        open_frame(0);
        send(0, 8'h81);
        close_frame(0);
        check("params_a_hdr_only", 64'(params_a), 64'hAA33_77BB);

        // 16-bit words: trailing partial byte discarded
        open_frame(1);
        send(1, 8'h81); send(1, 8'h12); send(1, 8'h34); send(1, 8'h56);
        push_b(64'hA5A5_A5A5_1234_A5A5);
        close_frame(1);

        open_frame(1);
        send(1, 8'h83); send(1, 8'hDE); send(1, 8'hAD); send(1, 8'hBE); send(1, 8'hEF);
        push_b(64'hDEAD_A5A5_1234_BEEF);
        close_frame(1);

        open_frame(1);
        send(1, 8'h00); send(1, 8'h01); send(1, 8'h02); send(1, 8'h03); send(1, 8'h04);
        push_b(64'hDEAD_A5A5_1234_0102);
        close_frame(1);

        // Reset in the middle of a frame
        open_frame(0);
        send(0, 8'h80); send(0, 8'hAA);
        rst = 1'b0;
        #1;
        check("midrst_params_a", 64'(params_a), 64'h0);
        check("midrst_busy_a",   64'(busy_a),   64'h0);
        check("midrst_err_a",    64'(err_a),    64'h0);
        check("midrst_params_b", params_b,      64'hA5A5_A5A5_A5A5_A5A5);
        tick();
        rst = 1'b1;
        tick();
        send(0, 8'h81); send(0, 8'h99);
        check("no_start_after_rst", 64'(busy_a), 64'h0);
        close_frame(0);
        check("params_a_after_rst", 64'(params_a), 64'h0);

        open_frame(0);
        send(0, 8'h80);
        send(0, 8'h7F); send(0, 8'h0C); send(0, 8'h01); send(0, 8'h10);
        push_a(32'h1001_0C7F);
        close_frame(0);
        check("err_a_final", 64'(err_a), 64'h0);

        repeat (5) tick();
        check("qa_drained", 64'(qa.size()), 64'h0);
        check("qb_drained", 64'(qb.size()), 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
